// File: rtl/pwm_symbol_encoder_pkg.sv
// Shared definitions for the PWM symbol encoder: symbol length default and FSM encoding.
package pwm_symbol_encoder_pkg;

    // Bits per PWM symbol on the modulator side; the encoder must produce the same length.
    localparam int unsigned AM_PWM_STEPS = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of 2 so pointers wrap freely.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rptr_q];

    // A push while full is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_symbol_encoder.sv
// Converts a stream of unsigned samples into MSB-first thermometer PWM symbols, one per sym_req.
module pwm_symbol_encoder
    import pwm_symbol_encoder_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned PWM_STEPS    = AM_PWM_STEPS,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_WIDTH-1:0]       s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          sym_req,
    output logic [PWM_STEPS-1:0]          symbol,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DW = $clog2(PWM_STEPS);
    localparam int unsigned PW = SAMPLE_WIDTH + DW;

    logic [SAMPLE_WIDTH-1:0] fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    load_nd;

    logic [PW-1:0]           product;
    logic [DW-1:0]           duty;
    logic [PWM_STEPS-1:0]    therm;

    logic [DW-1:0]           nd_q;
    logic                    nd_v_q;
    logic [PWM_STEPS-1:0]    symbol_q;
    logic                    underrun_q;
    state_t                  state_q;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;
    // Refill staging whenever it is empty or being consumed this cycle.
    assign load_nd   = (!nd_v_q || sym_req) && !fifo_empty;

    sync_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (load_nd),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Scale head sample to a duty count; PWM_STEPS is a power of 2 so the multiply is a shift.
    always_comb begin
        product = PW'(fifo_rdata) << DW;
        duty    = product[SAMPLE_WIDTH +: DW];
    end

    // Thermometer code of the staged duty, ones packed from the MSB downward.
    always_comb begin
        therm = '0;
        for (int i = 0; i < PWM_STEPS; i++) begin
            therm[i] = (DW'(PWM_STEPS - 1 - i) < nd_q);
        end
    end

    // Staging register and output symbol register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nd_q     <= '0;
            nd_v_q   <= 1'b0;
            symbol_q <= '0;
        end else begin
            if (load_nd) begin
                nd_q   <= duty;
                nd_v_q <= 1'b1;
            end else if (sym_req) begin
                nd_v_q <= 1'b0;
            end
            if (sym_req && nd_v_q) begin
                symbol_q <= therm;
            end
        end
    end

    // Supply-state FSM with a registered underrun pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (sym_req) begin
                case (state_q)
                    ST_IDLE: begin
                        if (nd_v_q) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN, ST_STARVED: begin
                        if (nd_v_q) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q    <= ST_STARVED;
                            underrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign symbol   = symbol_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Directed self-checking bench for pwm_symbol_encoder (SAMPLE_WIDTH=8, PWM_STEPS=64, FIFO_DEPTH=4).
module tb_pwm_symbol_encoder;
    import pwm_symbol_encoder_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        sym_req;
    logic [63:0] symbol;
    logic        underrun;
    logic [2:0]  fifo_level;

    int n_cmp;
    int n_err;

    pwm_symbol_encoder #(
        .SAMPLE_WIDTH (8),
        .PWM_STEPS    (64),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sym_req    (sym_req),
        .symbol     (symbol),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] therm_of(input int n);
        logic [63:0] ones;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        return ~(ones >> n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        sym_req = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic push_one(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    task automatic req_one();
        sym_req = 1'b1;
        step();
        sym_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (symbol !== 64'h0) begin n_err++; $display("FAIL reset_symbol got %h want 0", symbol); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", underrun); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", s_ready); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        for (int k = 0; k < 3; k++) begin
            req_one();
            n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL idle_underrun_a got %b want 0", underrun); end
            step();
            n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL idle_underrun_b got %b want 0", underrun); end
        end
        n_cmp++; if (symbol !== 64'h0) begin n_err++; $display("FAIL idle_symbol got %h want 0", symbol); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL idle_state got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_symbols();
        logic [7:0]  din  [4];
        logic [63:0] dexp [4];
        din  = '{8'h80, 8'h04, 8'h00, 8'hFF};
        dexp = '{64'hFFFF_FFFF_0000_0000, 64'h8000_0000_0000_0000,
                 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_one(din[k]);
            step();
            req_one();
            n_cmp++; if (symbol !== dexp[k]) begin n_err++; $display("FAIL sym_%0d got %h want %h", k, symbol, dexp[k]); end
            n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL sym_underrun_%0d got %b want 0", k, underrun); end
        end
        n_cmp++; if (dut.state_q !== ST_RUN) begin n_err++; $display("FAIL sym_state got %0d want %0d", dut.state_q, ST_RUN); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [7];
        int acc;
        vals = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
        do_reset();
        acc = 0;
        s_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic rdy;
            s_data = vals[acc];
            rdy = s_ready;
            step();
            if (rdy) acc++;
        end
        n_cmp++; if (acc !== 5) begin n_err++; $display("FAIL bp_accepted got %0d want 5", acc); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", s_ready); end
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL bp_level got %0d want 4", fifo_level); end
        // Full: sym_req pops into staging, push is refused.
        s_data = vals[5];
        sym_req = 1'b1;
        step();
        n_cmp++; if (symbol !== 64'hF000_0000_0000_0000) begin n_err++; $display("FAIL bp_sym0 got %h want f000000000000000", symbol); end
        n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL bp_level_pop got %0d want 3", fifo_level); end
        // Simultaneous push and pop: level unchanged.
        step();
        n_cmp++; if (symbol !== 64'hFF00_0000_0000_0000) begin n_err++; $display("FAIL bp_sym1 got %h want ff00000000000000", symbol); end
        n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL bp_level_pp got %0d want 3", fifo_level); end
        sym_req = 1'b0;
        s_data = vals[6];
        step();
        s_valid = 1'b0;
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL bp_level_refill got %0d want 4", fifo_level); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_refill got %b want 0", s_ready); end
        // Drain: duties 12,16,20,24,28 in input order.
        for (int k = 0; k < 5; k++) begin
            req_one();
            n_cmp++;
            if (symbol !== therm_of(12 + 4 * k)) begin
                n_err++; $display("FAIL bp_drain_%0d got %h want %h", k, symbol, therm_of(12 + 4 * k));
            end
        end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL bp_level_end got %0d want 0", fifo_level); end
    endtask

    task automatic test_underrun();
        do_reset();
        push_one(8'h80);
        step();
        req_one();
        n_cmp++; if (symbol !== 64'hFFFF_FFFF_0000_0000) begin n_err++; $display("FAIL ur_sym got %h want ffffffff00000000", symbol); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_pre_%0d got %b want 0", k, underrun); end
            req_one();
            n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_pulse_%0d got %b want 1", k, underrun); end
            step();
            n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear_%0d got %b want 0", k, underrun); end
            n_cmp++; if (symbol !== 64'hFFFF_FFFF_0000_0000) begin n_err++; $display("FAIL ur_hold_%0d got %h want ffffffff00000000", k, symbol); end
        end
        n_cmp++; if (dut.state_q !== ST_STARVED) begin n_err++; $display("FAIL ur_state got %0d want %0d", dut.state_q, ST_STARVED); end
        push_one(8'h40);
        step();
        req_one();
        n_cmp++; if (symbol !== 64'hFFFF_0000_0000_0000) begin n_err++; $display("FAIL ur_recover got %h want ffff000000000000", symbol); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_recover_pulse got %b want 0", underrun); end
        n_cmp++; if (dut.state_q !== ST_RUN) begin n_err++; $display("FAIL ur_recover_state got %0d want %0d", dut.state_q, ST_RUN); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_one(8'h80);
        step();
        req_one();
        for (int k = 0; k < 4; k++) push_one(8'h11 + 8'(k));
        n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL ar_level_pre got %0d want 3", fifo_level); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (symbol !== 64'h0) begin n_err++; $display("FAIL ar_symbol got %h want 0", symbol); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL ar_level got %0d want 0", fifo_level); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready got %b want 1", s_ready); end
        #2;
        rst = 1'b1;
        step();
        req_one();
        step();
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ar_underrun got %b want 0", underrun); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL ar_state got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_modulator();
        logic [63:0] sreg;
        logic [63:0] cap;
        logic [63:0] seen;
        int          upulses;
        do_reset();
        sreg    = '0;
        cap     = '0;
        upulses = 0;
        s_data  = 8'h80;
        s_valid = 1'b1;
        for (int c = 0; c < 64 * 5; c++) begin
            sym_req = (c % 64 == 0);
            seen    = symbol;
            step();
            if (underrun) upulses++;
            if (c % 64 == 0) sreg = seen;
            else             sreg = {sreg[62:0], sreg[63]};
            cap = {cap[62:0], sreg[63]};
            if ((c % 64 == 63) && (c / 64 >= 2)) begin
                n_cmp++;
                if (cap !== 64'hFFFF_FFFF_0000_0000) begin
                    n_err++; $display("FAIL mod_period_%0d got %h want ffffffff00000000", c / 64, cap);
                end
            end
        end
        sym_req = 1'b0;
        s_valid = 1'b0;
        n_cmp++; if (upulses !== 0) begin n_err++; $display("FAIL mod_underrun got %0d want 0", upulses); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_symbols();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_modulator();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
